vx_mem_responder: RTL and testbench

Memory-side responder for the Vortex memory bus: the far end of an L2 memory port, standing in for system DRAM in on-chip/FPGA-less configurations and simulation. Accepts line-granular read/write requests on a valid/ready channel, serves them from a local byte-enabled line SRAM through a fixed-latency pipeline, and returns in-order read responses carrying the request tag. It uses credit-based flow control so a stalled response channel never drops data.

---
 rtl/vx_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_vx_mem_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// vx_mem_responder
// Memory-side responder standing in for system DRAM at the far end of an L2
// memory port. Line-granular read/write requests are served from a local
// byte-enabled line SRAM through a fixed-latency read pipeline. Read responses
// come back in accept order through a small response queue. Credit-based
// request flow control guarantees the queue never overflows.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous reset, active low (0 = in reset)
//   mem_req_valid   request valid
//   mem_req_rw      1 = write, 0 = read
//   mem_req_addr    line address
//   mem_req_data    write data (one full line)
//   mem_req_byteen  per-byte write enables
//   mem_req_tag     request tag, echoed on the read response
//   mem_req_ready   request accepted when valid & ready
//   mem_rsp_valid   read response valid
//   mem_rsp_data    read response line data
//   mem_rsp_tag     tag of the originating read
//   mem_rsp_ready   response consumed when valid & ready
//   perf_reads      accepted read count (wraps at 2**32)
//   perf_writes     accepted write count (wraps at 2**32)
//   busy            a read is in the pipeline or in the response queue

`timescale 1ns/1ps

module vx_mem_responder #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8,
  parameter int LATENCY    = 2,
  parameter int RSQ_SIZE   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  input  logic                   mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic [8*DATA_SIZE-1:0] mem_req_data,
  input  logic [DATA_SIZE-1:0]   mem_req_byteen,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag,
  output logic                   mem_req_ready,
  output logic                   mem_rsp_valid,
  output logic [8*DATA_SIZE-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
  input  logic                   mem_rsp_ready,
  output logic [31:0]            perf_reads,
  output logic [31:0]            perf_writes,
  output logic                   busy
);

  localparam int DATA_W = 8 * DATA_SIZE;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int PTR_W  = $clog2(RSQ_SIZE);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(RSQ_SIZE);

  // Line storage; deliberately not reset so contents survive a reset.
  logic [DATA_W-1:0]    lineMem_q  [DEPTH];

  logic [LATENCY-1:0]   pipeValid_q, pipeValid_d;
  logic [DATA_W-1:0]    pipeData_q [LATENCY];
  logic [TAG_WIDTH-1:0] pipeTag_q  [LATENCY];

  logic [DATA_W-1:0]    fifoData_q [RSQ_SIZE];
  logic [TAG_WIDTH-1:0] fifoTag_q  [RSQ_SIZE];
  logic [CNT_W-1:0]     wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]     rdPtr_q, rdPtr_d;

  logic [31:0]          perfReads_q, perfReads_d;
  logic [31:0]          perfWrites_q, perfWrites_d;
  logic                 readyEn_q;

  logic [CNT_W-1:0]     pipeCnt;
  logic [CNT_W-1:0]     fifoCnt;
  logic [CNT_W-1:0]     inflight;
  logic                 reqFire, rdFire, wrFire;
  logic                 push, pop, rspValid;
  logic [PTR_W-1:0]     wrIdx, rdIdx;

  // Number of reads currently travelling down the latency pipeline.
  always_comb begin
    pipeCnt = '0;
    for (int i = 0; i < LATENCY; i++) begin
      pipeCnt = pipeCnt + CNT_W'(pipeValid_q[i]);
    end
  end

  // Pointers carry one extra bit so a full queue differs from an empty one.
  assign fifoCnt  = wrPtr_q - rdPtr_q;
  assign inflight = pipeCnt + fifoCnt;
  assign wrIdx    = wrPtr_q[PTR_W-1:0];
  assign rdIdx    = rdPtr_q[PTR_W-1:0];

  // Every accepted read is guaranteed a queue slot: ready depends only on
  // registered occupancy, never on the current request, so a pop this cycle
  // frees its credit on the next one.
  assign mem_req_ready = readyEn_q & (inflight < CREDITS);
  assign reqFire       = mem_req_valid & mem_req_ready;
  assign rdFire        = reqFire & ~mem_req_rw;
  assign wrFire        = reqFire & mem_req_rw;

  assign push     = pipeValid_q[LATENCY-1];
  assign rspValid = (wrPtr_q != rdPtr_q);
  assign pop      = rspValid & mem_rsp_ready;

  // Next-state for pipeline valids, queue pointers and counters.
  always_comb begin
    pipeValid_d    = '0;
    pipeValid_d[0] = rdFire;
    for (int i = 1; i < LATENCY; i++) begin
      pipeValid_d[i] = pipeValid_q[i-1];
    end
    wrPtr_d      = push ? wrPtr_q + CNT_W'(1) : wrPtr_q;
    rdPtr_d      = pop ? rdPtr_q + CNT_W'(1) : rdPtr_q;
    perfReads_d  = rdFire ? perfReads_q + 32'd1 : perfReads_q;
    perfWrites_d = wrFire ? perfWrites_q + 32'd1 : perfWrites_q;
  end

  // Control state; readyEn_q holds ready low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readyEn_q    <= 1'b0;
      pipeValid_q  <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      perfReads_q  <= '0;
      perfWrites_q <= '0;
    end else begin
      readyEn_q    <= 1'b1;
      pipeValid_q  <= pipeValid_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      perfReads_q  <= perfReads_d;
      perfWrites_q <= perfWrites_d;
    end
  end

  // Byte-enabled line write.
  always_ff @(posedge clk) begin
    if (wrFire) begin
      for (int b = 0; b < DATA_SIZE; b++) begin
        if (mem_req_byteen[b]) begin
          lineMem_q[mem_req_addr][8*b +: 8] <= mem_req_data[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 is the synchronous SRAM read; later stages just carry data along.
  // Payload registers need no reset because only the valid bits matter.
  always_ff @(posedge clk) begin
    if (rdFire) begin
      pipeData_q[0] <= lineMem_q[mem_req_addr];
      pipeTag_q[0]  <= mem_req_tag;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipeData_q[i] <= pipeData_q[i-1];
      pipeTag_q[i]  <= pipeTag_q[i-1];
    end
  end

  // Response queue storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoData_q[wrIdx] <= pipeData_q[LATENCY-1];
      fifoTag_q[wrIdx]  <= pipeTag_q[LATENCY-1];
    end
  end

  // Payload is forced to zero while no response is offered.
  assign mem_rsp_valid = rspValid;
  assign mem_rsp_data  = rspValid ? fifoData_q[rdIdx] : '0;
  assign mem_rsp_tag   = rspValid ? fifoTag_q[rdIdx] : '0;
  assign perf_reads    = perfReads_q;
  assign perf_writes   = perfWrites_q;
  assign busy          = (inflight != '0);

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb_vx_mem_responder
// Self-checking bench for vx_mem_responder. A behavioural model tracks
// outstanding reads as a queue of {tag, data, ready-cycle} entries plus a
// line-keyed memory image. The DUT outputs are compared with the model on
// every falling edge. Directed scenarios pin the model with literal
// expectations. A randomized phase then exercises mixed traffic with random
// response backpressure.

`timescale 1ns/1ps

module tb_vx_mem_responder;

  localparam int DS   = 64;
  localparam int AW   = 10;
  localparam int TW   = 8;
  localparam int LAT  = 2;
  localparam int RSQ  = 4;
  localparam int DW   = 8 * DS;

  logic          clk;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [DS-1:0] mem_req_byteen;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;
  logic [31:0]   perf_reads;
  logic [31:0]   perf_writes;
  logic          busy;

  vx_mem_responder #(
    .DATA_SIZE (DS),
    .ADDR_WIDTH(AW),
    .TAG_WIDTH (TW),
    .LATENCY   (LAT),
    .RSQ_SIZE  (RSQ)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_byteen(mem_req_byteen),
    .mem_req_tag   (mem_req_tag),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_tag   (mem_rsp_tag),
    .mem_rsp_ready (mem_rsp_ready),
    .perf_reads    (perf_reads),
    .perf_writes   (perf_writes),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    bit            known;
    int            avail;
  } rsp_t;

  rsp_t          expQ[$];
  logic [DW-1:0] modelMem[int];
  bit            modelKnown[int];
  int            outstanding = 0;
  int unsigned   modelReads  = 0;
  int unsigned   modelWrites = 0;
  bit            armed       = 1'b0;
  int            cyc         = 0;
  logic [TW-1:0] popTags[$];

  localparam logic [DW-1:0] PAT_A   = {8{64'hA1A2A3A4A5A6A7A8}};
  localparam logic [DW-1:0] PAT_B   = {8{64'hB1B2B3B4B5B6B7B8}};
  localparam logic [DW-1:0] PAT_AB  = {{7{64'hA1A2A3A4A5A6A7A8}}, 64'hB1B2B3B4B5B6B7B8};
  localparam logic [DW-1:0] PAT_C   = {16{32'hC0DE_1234}};

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] randLine();
    logic [DW-1:0] l;
    for (int w = 0; w < DW / 32; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  // Model: credits are simply reads accepted but not yet consumed; a read's
  // response becomes visible LAT cycles after its accept edge.
  logic [DW-1:0] mLine;
  bit            mKnown;
  bit            expReady;
  bit            expValid;
  int            mAddr;
  rsp_t          mEnt;

  always @(negedge clk) begin
    if (!reset) begin
      expQ.delete();
      outstanding = 0;
      modelReads  = 0;
      modelWrites = 0;
      armed       = 1'b0;
      checkOutput("rst_req_ready", DW'(mem_req_ready), '0);
      checkOutput("rst_rsp_valid", DW'(mem_rsp_valid), '0);
      checkOutput("rst_rsp_data",  mem_rsp_data, '0);
      checkOutput("rst_rsp_tag",   DW'(mem_rsp_tag), '0);
      checkOutput("rst_perf_reads", DW'(perf_reads), '0);
      checkOutput("rst_perf_writes", DW'(perf_writes), '0);
      checkOutput("rst_busy",      DW'(busy), '0);
    end else begin
      expReady = armed && (outstanding < RSQ);
      expValid = (expQ.size() > 0) && (expQ[0].avail <= cyc);
      checkOutput("req_ready",  DW'(mem_req_ready), DW'(expReady));
      checkOutput("rsp_valid",  DW'(mem_rsp_valid), DW'(expValid));
      checkOutput("busy",       DW'(busy), DW'(outstanding != 0));
      checkOutput("perf_reads", DW'(perf_reads), DW'(modelReads));
      checkOutput("perf_writes", DW'(perf_writes), DW'(modelWrites));
      if (expValid && mem_rsp_valid) begin
        checkOutput("rsp_tag", DW'(mem_rsp_tag), DW'(expQ[0].tag));
        if (expQ[0].known) checkOutput("rsp_data", mem_rsp_data, expQ[0].data);
      end
      if (expValid && mem_rsp_ready) begin
        popTags.push_back(mem_rsp_tag);
        void'(expQ.pop_front());
        outstanding--;
      end
      if (mem_req_valid && expReady) begin
        mAddr = int'(mem_req_addr);
        if (mem_req_rw) begin
          mLine  = modelMem.exists(mAddr) ? modelMem[mAddr] : '0;
          mKnown = modelKnown.exists(mAddr) ? modelKnown[mAddr] : 1'b0;
          for (int b = 0; b < DS; b++)
            if (mem_req_byteen[b]) mLine[8*b +: 8] = mem_req_data[8*b +: 8];
          modelMem[mAddr]   = mLine;
          modelKnown[mAddr] = mKnown || (mem_req_byteen == '1);
          modelWrites++;
        end else begin
          mEnt.tag   = mem_req_tag;
          mEnt.data  = modelMem.exists(mAddr) ? modelMem[mAddr] : '0;
          mEnt.known = modelKnown.exists(mAddr) ? modelKnown[mAddr] : 1'b0;
          mEnt.avail = cyc + 1 + LAT;
          expQ.push_back(mEnt);
          outstanding++;
          modelReads++;
        end
      end
      armed = 1'b1;
    end
    cyc++;
  end

  // Drives one request and holds it until accepted; entered and left at
  // posedge+1.
  task automatic applyStimulus(input logic rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [DS-1:0] be,
                               input logic [TW-1:0] tag);
    int waitCnt = 0;
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_data   = data;
    mem_req_byteen = be;
    mem_req_tag    = tag;
    @(negedge clk);
    while (!mem_req_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!mem_req_ready) begin
      errors++;
      $display("[TB] FAIL req_timeout actual=ready_low expected=accept");
    end
    @(posedge clk);
    #1;
    mem_req_valid = 1'b0;
  endtask

  // Checks the exact cycle a single read's response appears.
  task automatic expectResponse(input string name, input logic [DW-1:0] data,
                                input logic [TW-1:0] tag);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      checkOutput({name, "_early"}, DW'(mem_rsp_valid), '0);
    end
    @(negedge clk);
    checkOutput({name, "_valid"}, DW'(mem_rsp_valid), DW'(1));
    checkOutput({name, "_data"}, mem_rsp_data, data);
    checkOutput({name, "_tag"}, DW'(mem_rsp_tag), DW'(tag));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  int sent;
  int accCnt;
  int cycles;

  initial begin
    reset          = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_byteen = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;

    $display("[TB] reset and ready release");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_ready", DW'(mem_req_ready), '0);
    checkOutput("init_busy", DW'(busy), '0);
    reset = 1'b1;
    #1;
    checkOutput("release_ready_before_edge", DW'(mem_req_ready), '0);
    @(posedge clk);
    #1;
    checkOutput("release_ready_after_edge", DW'(mem_req_ready), DW'(1));

    $display("[TB] full write then read-after-write");
    applyStimulus(1'b1, 10'h005, PAT_A, '1, 8'h00);
    applyStimulus(1'b0, 10'h005, '0, '0, 8'h3C);
    expectResponse("raw", PAT_A, 8'h3C);

    $display("[TB] partial write merge");
    applyStimulus(1'b1, 10'h005, PAT_B, 64'h0000_0000_0000_00FF, 8'h00);
    applyStimulus(1'b0, 10'h005, '0, '0, 8'h3D);
    expectResponse("partial", PAT_AB, 8'h3D);

    $display("[TB] credit exhaustion with stalled responses");
    popTags.delete();
    mem_rsp_ready = 1'b0;
    sent          = 0;
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 10'h005;
    mem_req_tag   = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) sent++;
      @(posedge clk);
      #1;
      mem_req_tag = 8'(sent);
      if (sent == 8) mem_req_valid = 1'b0;
    end
    checkOutput("bp_accepted", DW'(sent), DW'(RSQ));
    checkOutput("bp_ready_low", DW'(mem_req_ready), '0);
    checkOutput("bp_busy", DW'(busy), DW'(1));
    mem_rsp_ready = 1'b1;
    for (int c = 0; c < 60 && !(sent == 8 && popTags.size() == 8); c++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) sent++;
      @(posedge clk);
      #1;
      mem_req_tag = 8'(sent);
      if (sent == 8) mem_req_valid = 1'b0;
    end
    checkOutput("bp_sent_all", DW'(sent), DW'(8));
    checkOutput("bp_rsp_count", DW'(popTags.size()), DW'(8));
    for (int i = 0; i < 8 && i < popTags.size(); i++)
      checkOutput("bp_order", DW'(popTags[i]), DW'(i));

    $display("[TB] randomized traffic");
    for (int a = 0; a < 16; a++)
      applyStimulus(1'b1, 10'h100 + 10'(a), randLine(), '1, 8'h00);
    accCnt = 0;
    cycles = 0;
    while (accCnt < 10000 && cycles < 40000) begin
      mem_req_valid  = ($urandom_range(0, 9) < 7);
      mem_req_rw     = ($urandom_range(0, 2) == 0);
      mem_req_addr   = 10'h100 + 10'($urandom_range(0, 15));
      mem_req_data   = randLine();
      mem_req_byteen = {$urandom, $urandom};
      mem_req_tag    = 8'($urandom);
      mem_rsp_ready  = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) accCnt++;
      @(posedge clk);
      #1;
      cycles++;
    end
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;
    checkOutput("rand_accepted", DW'(accCnt), DW'(10000));
    for (int c = 0; c < 100 && (busy || expQ.size() != 0); c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_busy", DW'(busy), '0);
    checkOutput("drain_model_empty", DW'(expQ.size()), '0);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 10'h1A0, PAT_C, '1, 8'h00);
    mem_rsp_ready = 1'b0;
    applyStimulus(1'b0, 10'h1A0, '0, '0, 8'h01);
    applyStimulus(1'b0, 10'h1A0, '0, '0, 8'h02);
    applyStimulus(1'b0, 10'h1A0, '0, '0, 8'h03);
    checkOutput("pre_rst_valid", DW'(mem_rsp_valid), DW'(1));
    checkOutput("pre_rst_busy", DW'(busy), DW'(1));
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", DW'(mem_rsp_valid), '0);
    checkOutput("midrst_busy", DW'(busy), '0);
    checkOutput("midrst_perf_reads", DW'(perf_reads), '0);
    checkOutput("midrst_perf_writes", DW'(perf_writes), '0);
    checkOutput("midrst_ready", DW'(mem_req_ready), '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mem_rsp_ready = 1'b1;
    applyStimulus(1'b0, 10'h1A0, '0, '0, 8'h77);
    expectResponse("post_rst", PAT_C, 8'h77);
    checkOutput("post_rst_perf_reads", DW'(perf_reads), DW'(1));

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
